// File: rtl/decode_issue_if.sv
// decode_issue_if: instruction, operand bundle and write-back signals of the decode/issue stage
interface decode_issue_if;
  logic [31:0] Instr;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Reg1;
  logic [31:0] Reg2;
  logic [4:0]  IV_ShftRor;
  logic [15:0] IV_Mov;
  logic [3:0]  OpCode;
  logic [3:0]  Cond;
  logic        S;
  logic [3:0]  Flag;
  logic [3:0]  Rd;
  logic        is_mem;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flag_we;
  logic [3:0]  flag_in;
  modport master (
    output Instr, in_valid, out_ready, wb_en, wb_addr, wb_data, flag_we, flag_in,
    input  in_ready, out_valid, Reg1, Reg2, IV_ShftRor, IV_Mov, OpCode, Cond, S, Flag, Rd, is_mem
  );
  modport slave (
    input  Instr, in_valid, out_ready, wb_en, wb_addr, wb_data, flag_we, flag_in,
    output in_ready, out_valid, Reg1, Reg2, IV_ShftRor, IV_Mov, OpCode, Cond, S, Flag, Rd, is_mem
  );
endinterface

// File: rtl/decode_issue.sv
// decode_issue: decodes Instr, reads the register file with write-back bypass, issues a registered ALU bundle
module decode_issue #(
  parameter int REGS = 16
) (
  input logic         clk,
  input logic         rst_n,
  decode_issue_if.slave bus
);
  logic [31:0] rf_q [REGS];
  logic [3:0]  flag_q, flag_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [4:0]  shft_q;
  logic [15:0] mov_q;
  logic [3:0]  op_q, cond_q, rd_q, flag_out_q;
  logic        s_q, s_d, is_mem_q;
  logic [3:0]  rn, rm, op;
  logic        acc;
  assign rn  = bus.Instr[18:15];
  assign rm  = bus.Instr[14:11];
  assign op  = bus.Instr[27:24];
  assign bus.in_ready = rst_n & (!out_valid_q | bus.out_ready);
  assign acc = bus.in_valid & bus.in_ready;
  always_comb begin
    reg1_d      = (bus.wb_en && bus.wb_addr == rn) ? bus.wb_data : rf_q[rn];
    reg2_d      = (bus.wb_en && bus.wb_addr == rm) ? bus.wb_data : rf_q[rm];
    flag_d      = bus.flag_we ? bus.flag_in : flag_q;
    s_d         = (op == 4'b1011) | bus.Instr[23];
    out_valid_d = acc | (out_valid_q & !bus.out_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
      flag_q <= '0;
    end else begin
      if (bus.wb_en) rf_q[bus.wb_addr] <= bus.wb_data;
      flag_q <= flag_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      shft_q      <= '0;
      mov_q       <= '0;
      op_q        <= '0;
      cond_q      <= '0;
      rd_q        <= '0;
      flag_out_q  <= '0;
      s_q         <= 1'b0;
      is_mem_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (acc) begin
        reg1_q     <= reg1_d;
        reg2_q     <= reg2_d;
        shft_q     <= bus.Instr[10:6];
        mov_q      <= bus.Instr[15:0];
        op_q       <= op;
        cond_q     <= bus.Instr[31:28];
        rd_q       <= bus.Instr[22:19];
        flag_out_q <= flag_d;
        s_q        <= s_d;
        is_mem_q   <= op[3] & op[2];
      end
    end
  end
  assign bus.out_valid  = out_valid_q;
  assign bus.Reg1       = reg1_q;
  assign bus.Reg2       = reg2_q;
  assign bus.IV_ShftRor = shft_q;
  assign bus.IV_Mov     = mov_q;
  assign bus.OpCode     = op_q;
  assign bus.Cond       = cond_q;
  assign bus.S          = s_q;
  assign bus.Flag       = flag_out_q;
  assign bus.Rd         = rd_q;
  assign bus.is_mem     = is_mem_q;
endmodule
